stereo_capture_sequencer: RTL and testbench
===========================================

// Module: stereo_capture_sequencer
// PURPOSE
//  Sequences one stereo capture through both AL422 FIFOs: arms each camera's write side on its own
//  frame boundary, then hands the read side to the image buffer reader, left camera then right.
//  Sits between the frame-request logic and the dual image buffer; it owns the FIFO write controls
//  and schedules the reader. Single clock domain (fifo_rck); camera VSYNCs are synchronised inside.
// PARAMETERS
//  WRST_CYCLES     4        width of each fifo_wrst low pulse, in fifo_rck cycles (1..15)
//  TIMEOUT_CYCLES  4000000  per-state watchdog limit, in fifo_rck cycles (24-bit counter)
//  VSYNC_POL       1        1: VSYNC is active-high; 0: active-low (inverted after sync)
// PORTS
//  fifo_rck     in   1  system clock, also the FIFO read clock
//  rst          in   1  synchronous, active-high reset
//  capture_req  in   1  one-cycle request to capture a stereo pair
//  vsync1       in   1  camera 1 (left) VSYNC, asynchronous
//  vsync2       in   1  camera 2 (right) VSYNC, asynchronous
//  rd_done      in   1  reader finished one image (one-cycle pulse)
//  fifo_wrst1   out  1  FIFO 1 write-pointer reset, active-low
//  fifo_wrst2   out  1  FIFO 2 write-pointer reset, active-low
//  fifo_we1     out  1  FIFO 1 write enable, active-low
//  fifo_we2     out  1  FIFO 2 write enable, active-low
//  rd_start     out  1  one-cycle pulse telling the reader to begin one image
//  rd_sel       out  1  image being read: 0 = left/FIFO 1, 1 = right/FIFO 2
//  busy         out  1  high in every state except IDLE
//  pair_ready   out  1  high from DONE until the next accepted capture_req
//  timeout_err  out  1  sticky watchdog flag, cleared by accepted capture_req or rst
// BEHAVIOUR
//  Reset values (cycle after rst high): state IDLE; wrst1/2 = 1; we1/2 = 1; rd_start = 0;
//  rd_sel = 0; busy = 0; pair_ready = 0; timeout_err = 0; sync flops 0; watchdog 0.
//  VSYNC path: 2-flop synchroniser per camera, then polarity fixed by VSYNC_POL, then a third flop
//  for edge detect. fstart = active->inactive edge; fend = inactive->active edge.
//  States:
//   IDLE: capture_req -> ARM; clears pair_ready and timeout_err in the same cycle.
//   ARM/WRITE: the two cameras run independently. Each camera waits for its fstart, then drives
//    wrst low for WRST_CYCLES and we low from that fstart cycle. It deasserts we (high) on the next
//    fend and sets its cam_done flag. When both cam_done are set -> RD_L.
//    If fstart and fend arrive on the same cycle, fend is ignored for that cycle.
//   RD_L: rd_sel = 0; rd_start is pulsed in the entry cycle only. rd_done is sampled from the
//    following cycle; rd_done -> RD_R.
//   RD_R: same as RD_L with rd_sel = 1; rd_done -> DONE.
//   DONE: one cycle; pair_ready is set to 1 -> IDLE.
//   ERR: one cycle; we1/2 and wrst1/2 forced high; timeout_err set -> IDLE.
//  Watchdog: cleared on every state change; counts in ARM, WRITE, RD_L and RD_R.
//   Count reaching TIMEOUT_CYCLES-1 -> ERR. Timeout has priority over a same-cycle transition.
//  capture_req while busy: ignored, not queued. rd_done outside RD_L/RD_R: ignored.
//  rd_done in the rd_start cycle: ignored.
//  we and wrst are high in every state except ARM/WRITE.
//  rst mid-operation: all outputs return to reset values on the next edge, even with we low.
//  rd_sel holds its last value in IDLE.
// TESTING
//  1 Reset with both vsync toggling -> wrst/we = 1, busy = 0, no rd_start for 100 cycles.
//  2 capture_req, then vsync1 fstart at t=50 and vsync2 fstart at t=80 (WRST_CYCLES=4)
//    -> wrst1 low for t=53..56 (3-cycle sync latency), wrst2 low for t=83..86;
//    each we low until its fend.
//  3 Both frames done, rd_done 200 cycles after each rd_start -> rd_start pulses with rd_sel 0
//    then 1; pair_ready = 1 one cycle after the second rd_done; busy = 0.
//  4 TIMEOUT_CYCLES=1000, vsync2 held inactive -> ERR at cycle 1000 after ARM entry;
//    we1/we2 = 1; timeout_err = 1 until the next capture_req.
//  5 capture_req repeated during WRITE and rd_done pulsed in IDLE -> no state change,
//    no extra rd_start.
//  6 rst asserted in RD_R and in WRITE -> outputs equal reset values next cycle;
//    a new capture_req restarts at ARM.

Source files
------------

// File: rtl/stereo_capture_sequencer_if.sv
// Bus bundle between the frame-request logic / image buffer reader and the
// stereo capture sequencer. Clock and reset stay outside as plain ports.
interface stereo_capture_sequencer_if;
    // Requests and camera/reader status into the sequencer
    logic capture_req;
    logic vsync1;
    logic vsync2;
    logic rd_done;
    // FIFO write controls (active-low) and reader scheduling out of the sequencer
    logic fifo_wrst1;
    logic fifo_wrst2;
    logic fifo_we1;
    logic fifo_we2;
    logic rd_start;
    logic rd_sel;
    logic busy;
    logic pair_ready;
    logic timeout_err;

    // Side that issues requests and observes the sequencer
    modport master (
        output capture_req, vsync1, vsync2, rd_done,
        input  fifo_wrst1, fifo_wrst2, fifo_we1, fifo_we2,
        input  rd_start, rd_sel, busy, pair_ready, timeout_err
    );

    // The sequencer itself
    modport slave (
        input  capture_req, vsync1, vsync2, rd_done,
        output fifo_wrst1, fifo_wrst2, fifo_we1, fifo_we2,
        output rd_start, rd_sel, busy, pair_ready, timeout_err
    );
endinterface

// File: rtl/stereo_capture_sequencer.sv
// Stereo capture sequencer: arms both AL422 FIFO write sides on their own
// camera frame start, closes each on its frame end, then schedules the reader
// for the left image followed by the right image. A per-state watchdog aborts
// a stuck capture. Everything runs on fifo_rck.
module stereo_capture_sequencer #(
    parameter int WRST_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter bit VSYNC_POL      = 1'b1
) (
    input  logic                         fifo_rck,
    input  logic                         rst,
    stereo_capture_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, ARM, WRITE, RD_L, RD_R, DONE, ERR} state_t;

    localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  WRST_LAST = 4'(WRST_CYCLES - 1);

    // Index 0 is the left camera / FIFO 1, index 1 the right camera / FIFO 2
    logic [1:0] vsync_raw;
    logic [1:0] fstart;
    logic [1:0] fend;

    assign vsync_raw = {bus.vsync2, bus.vsync1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic sync1_q;
            logic sync2_q;
            logic sync3_q;
            logic active;

            // Polarity is normalised after the two metastability flops so the
            // edge-detect flop always holds "frame active" as a 1.
            assign active = VSYNC_POL ? sync2_q : ~sync2_q;

            // Two-flop synchroniser plus one edge-detect stage per camera
            always_ff @(posedge fifo_rck) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    sync3_q <= 1'b0;
                end else begin
                    sync1_q <= vsync_raw[gi];
                    sync2_q <= sync1_q;
                    sync3_q <= active;
                end
            end

            assign fstart[gi] = sync3_q & ~active;
            assign fend[gi]   = ~sync3_q & active;
        end
    endgenerate

    state_t           state_q, state_d;
    logic [23:0]      wdog_q, wdog_d;
    logic [1:0]       started_q, started_d;
    logic [1:0]       cam_done_q, cam_done_d;
    logic [1:0][3:0]  wrst_cnt_q, wrst_cnt_d;
    logic [1:0]       wrst_n_q, wrst_n_d;
    logic [1:0]       we_n_q, we_n_d;
    logic             rd_start_q, rd_start_d;
    logic             rd_sel_q, rd_sel_d;
    logic             pair_ready_q, pair_ready_d;
    logic             timeout_err_q, timeout_err_d;
    logic             in_write;
    logic             counting;

    // Next-state, per-camera write control, watchdog and output flags
    always_comb begin
        state_d       = state_q;
        started_d     = started_q;
        cam_done_d    = cam_done_q;
        wrst_cnt_d    = wrst_cnt_q;
        wrst_n_d      = wrst_n_q;
        we_n_d        = we_n_q;
        rd_start_d    = 1'b0;
        rd_sel_d      = rd_sel_q;
        pair_ready_d  = pair_ready_q;
        timeout_err_d = timeout_err_q;
        in_write      = (state_q == ARM) || (state_q == WRITE);
        counting      = in_write || (state_q == RD_L) || (state_q == RD_R);

        // Each camera runs on its own: start on fstart, stop on the next fend
        if (in_write) begin
            for (int i = 0; i < 2; i++) begin
                if (!wrst_n_q[i]) begin
                    if (wrst_cnt_q[i] == 4'd0) begin
                        wrst_n_d[i] = 1'b1;
                    end else begin
                        wrst_cnt_d[i] = wrst_cnt_q[i] - 4'd1;
                    end
                end
                if (!started_q[i] && fstart[i]) begin
                    started_d[i]  = 1'b1;
                    wrst_n_d[i]   = 1'b0;
                    we_n_d[i]     = 1'b0;
                    wrst_cnt_d[i] = WRST_LAST;
                end else if (started_q[i] && !cam_done_q[i] && fend[i] && !fstart[i]) begin
                    we_n_d[i]     = 1'b1;
                    cam_done_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.capture_req) begin
                    state_d       = ARM;
                    pair_ready_d  = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ARM:   if (|started_d) state_d = WRITE;
            WRITE: if (&cam_done_q) state_d = RD_L;
            // rd_done in the rd_start cycle belongs to no image yet
            RD_L:  if (!rd_start_q && bus.rd_done) state_d = RD_R;
            RD_R:  if (!rd_start_q && bus.rd_done) state_d = DONE;
            DONE:  state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Watchdog wins over any transition decided above
        if (counting && (wdog_q == WDOG_LAST)) begin
            state_d = ERR;
        end
        wdog_d = ((state_d != state_q) || !counting) ? 24'd0 : wdog_q + 24'd1;

        // FIFO write side is only ever touched while capturing
        if ((state_d != ARM) && (state_d != WRITE)) begin
            started_d  = 2'b00;
            cam_done_d = 2'b00;
            wrst_cnt_d = '0;
            wrst_n_d   = 2'b11;
            we_n_d     = 2'b11;
        end

        if ((state_d != state_q) && ((state_d == RD_L) || (state_d == RD_R))) begin
            rd_start_d = 1'b1;
        end
        if (state_d == RD_L) begin
            rd_sel_d = 1'b0;
        end else if (state_d == RD_R) begin
            rd_sel_d = 1'b1;
        end
        if (state_d == DONE) begin
            pair_ready_d = 1'b1;
        end
        if (state_d == ERR) begin
            timeout_err_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge fifo_rck) begin
        if (rst) begin
            state_q       <= IDLE;
            wdog_q        <= 24'd0;
            started_q     <= 2'b00;
            cam_done_q    <= 2'b00;
            wrst_cnt_q    <= '0;
            wrst_n_q      <= 2'b11;
            we_n_q        <= 2'b11;
            rd_start_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
            pair_ready_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            started_q     <= started_d;
            cam_done_q    <= cam_done_d;
            wrst_cnt_q    <= wrst_cnt_d;
            wrst_n_q      <= wrst_n_d;
            we_n_q        <= we_n_d;
            rd_start_q    <= rd_start_d;
            rd_sel_q      <= rd_sel_d;
            pair_ready_q  <= pair_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.fifo_wrst1  = wrst_n_q[0];
    assign bus.fifo_wrst2  = wrst_n_q[1];
    assign bus.fifo_we1    = we_n_q[0];
    assign bus.fifo_we2    = we_n_q[1];
    assign bus.rd_start    = rd_start_q;
    assign bus.rd_sel      = rd_sel_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.pair_ready  = pair_ready_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_stereo_capture_sequencer.sv
// Directed bench for stereo_capture_sequencer. Output vector order in every
// expected value: {wrst1, wrst2, we1, we2, rd_start, rd_sel, busy, pair_ready, timeout_err}.
module tb_stereo_capture_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stereo_capture_sequencer_if bus();

    stereo_capture_sequencer #(
        .WRST_CYCLES    (4),
        .TIMEOUT_CYCLES (1000),
        .VSYNC_POL      (1'b1)
    ) dut (
        .fifo_rck (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] RST_VAL = 9'b1111_0_0_0_0_0;

    typedef struct {
        int         n;
        logic       cap;
        logic       v1;
        logic       v2;
        logic       rdd;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [8:0] outs();
        return {bus.fifo_wrst1, bus.fifo_wrst2, bus.fifo_we1, bus.fifo_we2,
                bus.rd_start, bus.rd_sel, bus.busy, bus.pair_ready, bus.timeout_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (wrst1 wrst2 we1 we2 rd_start rd_sel busy pair_ready timeout_err)",
                     name, act, exp);
        end
    endtask

    task automatic wait_rd_start(input int max_c, input string name);
        int k;
        k = 0;
        while ((bus.rd_start !== 1'b1) && (k < max_c)) begin
            step();
            k++;
        end
        checks++;
        if (bus.rd_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: rd_start got %b required 1 within %0d cycles", name, bus.rd_start, max_c);
        end
    endtask

    initial begin
        // Full capture, relative timing: vsync edges take 3 cycles to act
        tbl[0]  = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b1111_0_0_1_0_0}; // accept -> ARM
        tbl[1]  = '{2, 1'b0, 1'b0, 1'b1, 1'b0, 9'b1111_0_0_1_0_0}; // cam1 fstart in sync
        tbl[2]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b0101_0_0_1_0_0}; // wrst1/we1 low
        tbl[3]  = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 9'b0101_0_0_1_0_0}; // wrst1 low 4 total
        tbl[4]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1101_0_0_1_0_0}; // wrst1 released
        tbl[5]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1101_0_0_1_0_0};
        tbl[6]  = '{4, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1000_0_0_1_0_0}; // wrst2 low 4 cycles
        tbl[7]  = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 9'b1100_0_0_1_0_0}; // cam1 fend in sync
        tbl[8]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b1110_0_0_1_0_0}; // we1 high
        tbl[9]  = '{2, 1'b0, 1'b1, 1'b1, 1'b0, 9'b1110_0_0_1_0_0};
        tbl[10] = '{1, 1'b0, 1'b1, 1'b1, 1'b0, 9'b1111_0_0_1_0_0}; // we2 high
        tbl[11] = '{1, 1'b0, 1'b1, 1'b1, 1'b0, 9'b1111_1_0_1_0_0}; // RD_L entry pulse
        tbl[12] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 9'b1111_0_0_1_0_0}; // rd_done in start cycle ignored
        tbl[13] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 9'b1111_1_1_1_0_0}; // RD_R entry pulse
        tbl[14] = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 9'b1111_0_1_1_0_0};
        tbl[15] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 9'b1111_0_1_1_1_0}; // DONE, pair_ready
        tbl[16] = '{2, 1'b0, 1'b1, 1'b1, 1'b0, 9'b1111_0_1_0_1_0}; // IDLE, rd_sel held
        tbl[17] = '{2, 1'b0, 1'b1, 1'b1, 1'b1, 9'b1111_0_1_0_1_0}; // rd_done in IDLE ignored
        tbl[18] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b1111_0_1_1_0_0}; // new accept clears pair_ready

        bus.capture_req = 1'b0;
        bus.vsync1      = 1'b0;
        bus.vsync2      = 1'b0;
        bus.rd_done     = 1'b0;
        rst             = 1'b1;

        // Reset held with both vsyncs toggling
        for (int i = 0; i < 100; i++) begin
            bus.vsync1 = ((i % 4) < 2);
            bus.vsync2 = ((i % 6) < 3);
            step();
            chk("reset_hold", RST_VAL);
        end
        $display("reset held 100 cycles with vsync toggling");
        bus.vsync1 = 1'b1;
        bus.vsync2 = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_after_reset", RST_VAL);
        end

        // Table-driven full capture
        for (int r = 0; r < 19; r++) begin
            bus.capture_req = tbl[r].cap;
            bus.vsync1      = tbl[r].v1;
            bus.vsync2      = tbl[r].v2;
            bus.rd_done     = tbl[r].rdd;
            for (int c = 0; c < tbl[r].n; c++) begin
                step();
                chk($sformatf("vec%0d_c%0d", r, c), tbl[r].exp);
            end
            $display("vec %0d: cap=%b v1=%b v2=%b rd_done=%b held %0d cycles",
                     r, tbl[r].cap, tbl[r].v1, tbl[r].v2, tbl[r].rdd, tbl[r].n);
        end

        // capture_req held and rd_done pulsed while in ARM: nothing changes
        for (int i = 0; i < 3; i++) begin
            bus.rd_done = (i != 1);
            step();
            chk("arm_ignore_req", 9'b1111_0_1_1_0_0);
        end
        bus.capture_req = 1'b0;
        bus.rd_done     = 1'b0;
        bus.vsync1      = 1'b0;
        step();
        step();
        chk("arm_wait_sync", 9'b1111_0_1_1_0_0);
        step();
        chk("write_entry", 9'b0101_0_1_1_0_0);
        // capture_req and rd_done during WRITE are ignored
        bus.capture_req = 1'b1;
        bus.rd_done     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("write_ignore_req", 9'b0101_0_1_1_0_0);
        end
        step();
        chk("write_wrst_release", 9'b1101_0_1_1_0_0);
        $display("capture_req/rd_done ignored during ARM and WRITE");

        // Reset in WRITE with we1 low
        bus.capture_req = 1'b0;
        bus.rd_done     = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_in_write", RST_VAL);
        rst = 1'b0;

        // Watchdog: no vsync edges at all after ARM entry
        bus.capture_req = 1'b1;
        step();
        chk("timeout_arm_entry", 9'b1111_0_0_1_0_0);
        bus.capture_req = 1'b0;
        repeat (500) step();
        chk("timeout_mid", 9'b1111_0_0_1_0_0);
        repeat (499) step();
        chk("timeout_last_arm", 9'b1111_0_0_1_0_0);
        step();
        chk("timeout_err_state", 9'b1111_0_0_1_0_1);
        step();
        chk("timeout_idle", 9'b1111_0_0_0_0_1);
        repeat (5) step();
        chk("timeout_sticky", 9'b1111_0_0_0_0_1);
        bus.capture_req = 1'b1;
        step();
        chk("timeout_cleared", 9'b1111_0_0_1_0_0);
        bus.capture_req = 1'b0;
        $display("watchdog fired 1000 cycles after ARM entry");

        // Second capture through to RD_R, then reset there
        bus.vsync1 = 1'b1;
        repeat (4) step();
        bus.vsync1 = 1'b0;
        bus.vsync2 = 1'b0;
        repeat (4) step();
        chk("both_writing", 9'b0000_0_0_1_0_0);
        bus.vsync1 = 1'b1;
        bus.vsync2 = 1'b1;
        wait_rd_start(30, "wait_rd_l");
        chk("rd_l_entry", 9'b1111_1_0_1_0_0);
        repeat (199) step();
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("rd_r_entry", 9'b1111_1_1_1_0_0);
        repeat (50) step();
        chk("rd_r_wait", 9'b1111_0_1_1_0_0);
        rst = 1'b1;
        step();
        chk("rst_in_rd_r", RST_VAL);
        rst = 1'b0;
        step();
        chk("idle_after_rst_rd_r", RST_VAL);
        bus.capture_req = 1'b1;
        step();
        chk("restart_arm", 9'b1111_0_0_1_0_0);
        bus.capture_req = 1'b0;
        step();
        chk("restart_arm_hold", 9'b1111_0_0_1_0_0);
        $display("reset in RD_R returned to reset values; restart reached ARM");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
